note_seq_ctrl: RTL and testbench

NOTE_SEQ_CTRL -- requirements
Module: note_seq_ctrl

---
 rtl/note_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_note_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_seq_ctrl.sv
// Note-sequence controller: buffers incoming notes, steps them one at a time through an
// external classifier and reports one result per word, with per-type word counters.
module note_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_nota,
    input  logic       in_last,
    output logic       cls_reset,
    output logic       cls_ok,
    output logic [3:0] cls_nota,
    input  logic       cls_fim,
    input  logic [1:0] cls_tipo,
    output logic       res_valid,
    input  logic       res_ack,
    output logic [1:0] res_tipo,
    output logic       res_incomplete,
    output logic [7:0] cnt_nulo,
    output logic [7:0] cnt_adj,
    output logic [7:0] cnt_comp,
    output logic [7:0] cnt_adv,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StPulse, StSettle1, StSettle2, StDrain, StReport
    } state_e;

    state_e     r_state;
    state_e     w_state_d;

    logic [4:0] r_fifo [8];
    logic [2:0] r_wptr;
    logic [2:0] r_rptr;
    logic [3:0] r_count;
    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_head;

    logic       r_last;
    logic [3:0] r_cls_nota;
    logic       r_cls_reset;
    logic       r_cls_ok;
    logic       r_res_valid;
    logic [1:0] r_res_tipo;
    logic       r_res_inc;
    logic [7:0] r_cnt [4];

    logic       w_load;
    logic       w_capture;
    logic [1:0] w_cap_tipo;
    logic       w_cap_inc;
    logic       w_cls_reset_d;
    logic       w_cls_ok_d;
    logic       w_res_valid_d;
    logic       w_rpt_enter;
    logic [1:0] w_rpt_tipo;

    assign w_empty  = (r_count == 4'd0);
    assign w_full   = (r_count == 4'd8);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_fifo[r_rptr];
    assign in_ready = !w_full;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {in_last, in_nota};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 3'd1;
            end
            r_count <= r_count + {3'b000, w_push} - {3'b000, w_pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_capture  = 1'b0;
        w_cap_tipo = 2'b00;
        w_cap_inc  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_state_d = StLoad;
                end
            end
            StLoad:    w_state_d = StPulse;
            StPulse:   w_state_d = StSettle1;
            StSettle1: w_state_d = StSettle2;
            StSettle2: begin
                if (cls_fim) begin
                    w_capture  = 1'b1;
                    w_cap_tipo = cls_tipo;
                    w_state_d  = r_last ? StReport : StDrain;
                end else if (r_last) begin
                    // Word ended before the classifier decided.
                    w_capture = 1'b1;
                    w_cap_inc = 1'b1;
                    w_state_d = StReport;
                end else if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_state_d = StLoad;
                end
            end
            StDrain: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head[4]) begin
                        w_state_d = StReport;
                    end
                end
            end
            StReport: begin
                if (res_ack) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state.
    always_comb begin
        w_cls_reset_d = (w_state_d == StIdle);
        w_cls_ok_d    = (w_state_d == StPulse);
        w_res_valid_d = (w_state_d == StReport);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cls_reset <= 1'b1;
            r_cls_ok    <= 1'b0;
            r_res_valid <= 1'b0;
            r_cls_nota  <= '0;
            r_last      <= 1'b0;
            r_res_tipo  <= 2'b00;
            r_res_inc   <= 1'b0;
        end else begin
            r_cls_reset <= w_cls_reset_d;
            r_cls_ok    <= w_cls_ok_d;
            r_res_valid <= w_res_valid_d;
            if (w_load) begin
                r_cls_nota <= w_head[3:0];
                r_last     <= w_head[4];
            end
            if (w_capture) begin
                r_res_tipo <= w_cap_tipo;
                r_res_inc  <= w_cap_inc;
            end
        end
    end

    assign w_rpt_enter = (w_state_d == StReport) && (r_state != StReport);
    assign w_rpt_tipo  = w_capture ? w_cap_tipo : r_res_tipo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_rpt_enter && (r_cnt[w_rpt_tipo] != 8'hFF)) begin
            r_cnt[w_rpt_tipo] <= r_cnt[w_rpt_tipo] + 8'd1;
        end
    end

    assign cls_reset      = r_cls_reset;
    assign cls_ok         = r_cls_ok;
    assign cls_nota       = r_cls_nota;
    assign res_valid      = r_res_valid;
    assign res_tipo       = r_res_tipo;
    assign res_incomplete = r_res_inc;
    assign cnt_nulo       = r_cnt[0];
    assign cnt_adj        = r_cnt[1];
    assign cnt_comp       = r_cnt[2];
    assign cnt_adv        = r_cnt[3];
    assign busy           = (r_state != StIdle);

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl: a scripted classifier stub plus a word-level result/counter model.
module tb_note_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_nota = '0;
    logic       in_last = 1'b0;
    logic       cls_reset;
    logic       cls_ok;
    logic [3:0] cls_nota;
    logic       cls_fim = 1'b0;
    logic [1:0] cls_tipo = '0;
    logic       res_valid;
    logic       res_ack = 1'b0;
    logic [1:0] res_tipo;
    logic       res_incomplete;
    logic [7:0] cnt_nulo;
    logic [7:0] cnt_adj;
    logic [7:0] cnt_comp;
    logic [7:0] cnt_adv;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    int m_cnt [4] = '{0, 0, 0, 0};

    // Classifier script for the word in flight.
    logic [3:0] p_notes [8];
    int         p_fim_at = 0;
    logic [1:0] p_tipo = '0;
    int         st_cnt = 0;

    note_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_nota        (in_nota),
        .in_last        (in_last),
        .cls_reset      (cls_reset),
        .cls_ok         (cls_ok),
        .cls_nota       (cls_nota),
        .cls_fim        (cls_fim),
        .cls_tipo       (cls_tipo),
        .res_valid      (res_valid),
        .res_ack        (res_ack),
        .res_tipo       (res_tipo),
        .res_incomplete (res_incomplete),
        .cnt_nulo       (cnt_nulo),
        .cnt_adj        (cnt_adj),
        .cnt_comp       (cnt_comp),
        .cnt_adv        (cnt_adv),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stub: decides after note p_fim_at; before that drives junk on cls_tipo.
    always @(posedge clk) begin
        if (cls_reset) begin
            st_cnt   <= 0;
            cls_fim  <= 1'b0;
            cls_tipo <= 2'($urandom);
        end else if (cls_ok) begin
            check("cls_nota", cls_nota, p_notes[st_cnt]);
            st_cnt <= st_cnt + 1;
            if (st_cnt + 1 == p_fim_at) begin
                cls_fim  <= 1'b1;
                cls_tipo <= p_tipo;
            end else if (!cls_fim) begin
                cls_tipo <= 2'($urandom);
            end
        end
    end

    task automatic push(input logic [3:0] n, input bit l);
        int to;
        to = 0;
        in_valid = 1'b1;
        in_nota  = n;
        in_last  = l;
        while (!in_ready && to < 200) begin
            @(negedge clk);
            to++;
        end
        check("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_counters();
        check("cnt_nulo", cnt_nulo, m_cnt[0]);
        check("cnt_adj", cnt_adj, m_cnt[1]);
        check("cnt_comp", cnt_comp, m_cnt[2]);
        check("cnt_adv", cnt_adv, m_cnt[3]);
    endtask

    task automatic wait_result(input int len, input int fim_at, input logic [1:0] tipo);
        int         to;
        logic [1:0] et;
        bit         ei;
        int         nok;
        if (fim_at > 0) begin
            et = tipo;
            ei = 1'b0;
            nok = fim_at;
        end else begin
            et = 2'b00;
            ei = 1'b1;
            nok = len;
        end
        to = 0;
        while (!res_valid && to < 300) begin
            @(negedge clk);
            to++;
        end
        check("res_seen", res_valid, 1);
        if (res_valid) begin
            check("res_tipo", res_tipo, et);
            check("res_inc", res_incomplete, ei);
            check("n_cls_ok", st_cnt, nok);
            check("busy_rpt", busy, 1);
            if (m_cnt[et] < 255) m_cnt[et]++;
            check_counters();
        end
    endtask

    task automatic ack_result(input bit hold);
        if (!hold) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("res_hold", res_valid, 1);
            res_ack = 1'b1;
            @(negedge clk);
            res_ack = 1'b0;
        end else begin
            @(negedge clk);
        end
        check("res_drop", res_valid, 0);
        check("idle_between", busy, 0);
    endtask

    task automatic run_word(input int len, input int fim_at, input logic [1:0] tipo,
                            input bit hold);
        p_fim_at = fim_at;
        p_tipo   = tipo;
        res_ack  = hold;
        for (int i = 0; i < len; i++) begin
            push(p_notes[i], i == len - 1);
        end
        wait_result(len, fim_at, tipo);
        ack_result(hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        check("rst_cls_ok", cls_ok, 0);
        check("rst_cls_reset", cls_reset, 1);
        check("rst_cls_nota", cls_nota, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_tipo", res_tipo, 0);
        check("rst_res_inc", res_incomplete, 0);
        check("rst_busy", busy, 0);
        check_counters();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          ok_q [$];
        int          first_rv;
        int          to;
        int          len;
        logic [31:0] rdy [9];

        #1;
        do_reset();

        // Exact latency of a 4-note word.
        p_notes  = '{4'd1, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        p_fim_at = 4;
        p_tipo   = 2'b01;
        in_valid = 1'b1;
        in_nota  = 4'd1;
        in_last  = 1'b0;
        @(negedge clk);
        first_rv = -1;
        for (int c = 0; c < 20; c++) begin
            if (cls_ok) ok_q.push_back(c);
            if (res_valid && first_rv < 0) first_rv = c;
            if (c < 3) begin
                in_nota = p_notes[c + 1];
                in_last = (c == 2);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("ok_pulses", ok_q.size(), 4);
        foreach (ok_q[i]) check("ok_cycle", ok_q[i], 4 * i + 2);
        check("rv_cycle", first_rv, 17);
        wait_result(4, 4, 2'b01);
        ack_result(1'b0);

        p_notes = '{4'd1, 4'd2, 4'd6, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
        run_word(5, 5, 2'b11, 1'b0);
        p_notes = '{4'd3, 4'd4, 4'd15, 4'd2, 4'd8, 4'd0, 4'd0, 4'd0};
        run_word(5, 5, 2'b10, 1'b0);
        p_notes = '{4'd0, 4'd5, 4'd6, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        run_word(4, 1, 2'b00, 1'b0);

        // Incomplete word, then fill the FIFO while the result waits.
        p_notes  = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        p_fim_at = 0;
        push(4'd1, 1'b0);
        push(4'd2, 1'b1);
        wait_result(2, 0, 2'b00);
        for (int i = 0; i < 8; i++) p_notes[i] = 4'($urandom);
        for (int i = 0; i < 9; i++) begin
            rdy[i]   = 32'(in_ready);
            in_valid = 1'b1;
            in_nota  = (i < 8) ? p_notes[i] : 4'd9;
            in_last  = (i >= 7);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) check("fill_ready", rdy[i], (i < 8) ? 1 : 0);
        check("full_ready", in_ready, 0);
        check("stall_valid", res_valid, 1);
        p_fim_at = $urandom_range(0, 8);
        p_tipo   = 2'($urandom);
        ack_result(1'b0);
        wait_result(8, p_fim_at, p_tipo);
        ack_result(1'b0);
        repeat (5) @(negedge clk);
        check("no_ninth_busy", busy, 0);
        check("no_ninth_ready", in_ready, 1);

        // Acknowledge held high across three words.
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) p_notes[i] = 4'($urandom);
            run_word(3, w, 2'(w + 1), 1'b1);
        end
        res_ack = 1'b0;

        // Reset during the pulse of note 2.
        p_notes  = '{4'd1, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        p_fim_at = 0;
        for (int i = 0; i < 4; i++) push(p_notes[i], i == 3);
        to = 0;
        while (!(cls_ok && st_cnt == 1) && to < 100) begin
            @(negedge clk);
            to++;
        end
        check("rst_reach_pulse2", 32'(cls_ok && st_cnt == 1), 1);
        do_reset();
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", in_ready, 1);
        check_counters();

        // Random words.
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) p_notes[i] = 4'($urandom);
            run_word(len, $urandom_range(0, len), 2'($urandom), $urandom_range(0, 2) == 0);
        end
        res_ack = 1'b0;

        // Counter saturation.
        for (int w = 0; w < 258; w++) begin
            p_notes[0] = 4'($urandom);
            run_word(1, 1, 2'b01, 1'b1);
        end
        res_ack = 1'b0;
        check("adj_saturated", cnt_adj, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
